load_extend_ctrl: RTL
=====================

# load_extend_ctrl

Sequencer for the load path of the 4-stage MIPS pipeline. It accepts one load request (LB/LBU/LH/LHU/LW) from the memory stage and issues a word-aligned read to data memory over a req/ack handshake. It then selects the addressed byte or halfword from the returned big-endian word, sign- or zero-extends it to 32 bits and hands the result back with a one-cycle done pulse. It also flags misaligned or reserved-size loads and memory timeouts without touching memory state.

## Interface
- TIMEOUT, 255: maximum cycles mem_req may stay high without mem_ack before abort (1..65535).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- start  in  1  load request; sampled only in IDLE.
- ld_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend; ignored for word.
- addr  in  32  byte address of the load.
- busy  out  1  high in every state except IDLE.
- mem_req  out  1  read request, held until acknowledged.
- mem_addr  out  32  {addr[31:2],2'b00}, stable while mem_req is high.
- mem_ack  in  1  memory accepted the request and mem_rdata is valid this cycle.
- mem_rdata  in  32  read word, big-endian byte order.
- done  out  1  one-cycle pulse; rdata is valid.
- rdata  out  32  extended load result; holds until the next done.
- err  out  1  one-cycle pulse on misalignment, reserved size or timeout.
- err_code  out  2  01 misaligned, 10 reserved size, 11 timeout; holds until the next err.

## Operation
- States: IDLE, REQ, DONE, ERR.
- IDLE, start=1:
  - Latch ld_size, ld_unsigned and addr[1:0].
  - ld_size=11 -> ERR, code 10.
  - Halfword with addr[0]=1, or word with addr[1:0]!=00 -> ERR, code 01.
  - Otherwise -> REQ; mem_addr loads {addr[31:2],00}.
- REQ:
  - mem_req=1.
  - mem_ack=1 -> capture the extended result into rdata, go to DONE.
  - Otherwise the timeout counter increments; when it reaches TIMEOUT-1 without ack -> ERR, code 11, mem_req drops.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 for one cycle, err_code updated, then IDLE. No memory request is issued for code 01 or 10.
- Lane selection (big-endian):
  - byte offset 0/1/2/3 -> rdata bits [31:24]/[23:16]/[15:8]/[7:0].
  - halfword offset 0/2 -> [31:16]/[15:0].
  - word -> full word.
- Extension: bits above the selected lane are filled with the lane MSB if ld_unsigned=0, with 0 if ld_unsigned=1.
- start while busy is ignored, not queued.
- Inputs other than mem_ack and mem_rdata are not re-sampled after acceptance.

## Timing
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - busy, mem_req, done and err go to 0; rdata, mem_addr and err_code go to 0; the counter clears.
  - Applies mid-transaction: mem_req drops at that edge and no done or err is produced for the aborted load.
- start accepted at edge N:
  - mem_req=1 from N+1.
  - ack sampled at edge N+1 earliest; done=1 during cycle N+2 earliest.
  - Minimum start-to-done latency is 2 cycles; busy is high from N+1 through the done cycle.
- Error path: start at edge N -> err=1 during cycle N+1, busy=1 only in that cycle.
- Timeout: k cycles of mem_req without ack, with k=TIMEOUT -> err at cycle N+1+TIMEOUT. An ack arriving on the final counted cycle wins over the timeout.
- The next start is accepted in the cycle after done or err, when busy=0. Back-to-back loads therefore take 3 cycles each with a zero-wait memory.
- mem_ack while mem_req=0 is ignored.

## Test plan
- Reset mid-REQ: rst_n=0 while mem_req=1 -> mem_req=0, busy=0, no done, rdata=0; a following start works normally.
- LB at addr 0x1003, mem_rdata=0x12345680 with immediate ack -> done at start+2, mem_addr=0x1000, rdata=0xFFFFFF80. Same with LBU -> 0x00000080.
- LH at addr 0x2002, mem_rdata=0xAAAA8001 after 3 wait cycles -> rdata=0xFFFF8001, done 5 cycles after start. LHU at 0x2000 -> 0x0000AAAA.
- LW at 0x3001 -> err pulse next cycle, err_code=01, mem_req never high. ld_size=11 -> err_code=10.
- TIMEOUT=4 with mem_ack held low -> mem_req high for exactly 4 cycles, then err with err_code=11, busy=0 the following cycle.
- start pulsed every cycle during a LW with 2 wait states -> exactly one mem_req transaction and one done; the extra starts are ignored.

Source files
------------

// File: rtl/load_extend_ctrl_if.sv
// Bundle between the load-path sequencer and its two neighbours: the
// memory-stage requester (start/ld_* in, busy/done/err/rdata out) and the
// data memory (mem_req/mem_addr out, mem_ack/mem_rdata in).
interface load_extend_ctrl_if;
  logic        start;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic [31:0] addr;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  err_code;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Environment side: requester and data memory.
  modport master (
    output start, ld_size, ld_unsigned, addr, mem_ack, mem_rdata,
    input  busy, done, rdata, err, err_code, mem_req, mem_addr
  );

  // Controller side.
  modport slave (
    input  start, ld_size, ld_unsigned, addr, mem_ack, mem_rdata,
    output busy, done, rdata, err, err_code, mem_req, mem_addr
  );
endinterface

// File: rtl/load_extend_ctrl.sv
// Load-path sequencer: accepts one LB/LBU/LH/LHU/LW request, issues a
// word-aligned read, picks the big-endian byte/halfword lane, extends it
// to 32 bits and reports done, or flags misalignment/reserved size/timeout.
module load_extend_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  load_extend_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] EC_MISALIGN = 2'b01;
  localparam logic [1:0] EC_RSVD     = 2'b10;
  localparam logic [1:0] EC_TIMEOUT  = 2'b11;

  // Last counter value before the request is abandoned.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q,    state_d;
  logic [1:0]  size_q,     size_d;
  logic        uns_q,      uns_d;
  logic [1:0]  off_q,      off_d;
  logic [15:0] cnt_q,      cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] rdata_q,    rdata_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        busy_q,     busy_d;
  logic        mem_req_q,  mem_req_d;
  logic        done_q,     done_d;
  logic        err_q,      err_d;

  // Big-endian lane select followed by sign/zero extension.
  function automatic logic [31:0] extend_lane(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic        uns,
    input logic [1:0]  off
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    uns_d      = uns_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    rdata_d    = rdata_q;
    err_code_d = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          size_d = bus.ld_size;
          uns_d  = bus.ld_unsigned;
          off_d  = bus.addr[1:0];
          if (bus.ld_size == SZ_RSVD) begin
            state_d    = S_ERR;
            err_code_d = EC_RSVD;
          end else if ((bus.ld_size == SZ_HALF && bus.addr[0]) ||
                       (bus.ld_size == SZ_WORD && bus.addr[1:0] != 2'b00)) begin
            state_d    = S_ERR;
            err_code_d = EC_MISALIGN;
          end else begin
            state_d    = S_REQ;
            mem_addr_d = {bus.addr[31:2], 2'b00};
            cnt_d      = 16'd0;
          end
        end
      end
      S_REQ: begin
        // An ack on the last counted cycle still completes the load.
        if (bus.mem_ack) begin
          rdata_d = extend_lane(bus.mem_rdata, size_q, uns_q, off_q);
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d    = S_ERR;
          err_code_d = EC_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    mem_req_d = (state_d == S_REQ);
    done_d    = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
  end

  // State and output registers; reset clears everything, aborting any load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      off_q      <= 2'b00;
      cnt_q      <= 16'd0;
      mem_addr_q <= 32'd0;
      rdata_q    <= 32'd0;
      err_code_q <= 2'b00;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      rdata_q    <= rdata_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
      mem_req_q  <= mem_req_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule
